bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data width.
REQ-002 The block SHALL have parameter ADDR_W, default 32, address width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, max consecutive locked transactions per owner (range 1..15).
REQ-004 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port req_m, input, 2, per-master transaction request (bit 0 = core data port, bit 1 = secondary master).
REQ-007 The block SHALL have port lock_m, input, 2, per-master request to keep the bus for the next transaction.
REQ-008 The block SHALL have port we_m, input, 2, per-master write enable.
REQ-009 The block SHALL have port addr_m, input, 2*ADDR_W, packed per-master address; master i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port wd_m, input, 2*DATA_W, packed per-master write data, same packing as addr_m.
REQ-011 The block SHALL have port gnt_m, output, 2, one-hot-or-zero grant; transaction issued when req_m[i] and gnt_m[i] are both high.
REQ-012 The block SHALL have port rvalid_m, output, 2, read data valid for master i.
REQ-013 The block SHALL have port rd_m, output, DATA_W, read data broadcast to both masters.
REQ-014 The block SHALL have port we_s, output, 1, slave-side write enable toward the interconnect.
REQ-015 The block SHALL have port addr_s, output, ADDR_W, slave-side address.
REQ-016 The block SHALL have port wd_s, output, DATA_W, slave-side write data.
REQ-017 The block SHALL have port rd_s, input, DATA_W, slave-side read data, valid one cycle after address (synchronous memory).

Function
REQ-018 The FSM SHALL have states IDLE (no owner) and LOCKED (owner holds bus); a 1-bit pointer last records the most recently served master; a counter burst_cnt counts locked transactions.
REQ-019 In IDLE, gnt_m SHALL be computed combinationally: a single requester wins; if both request, the master not equal to last wins.
REQ-020 In LOCKED, gnt_m SHALL equal the one-hot owner only when req_m[owner] is high; the other master SHALL NOT be granted.
REQ-021 When a transaction issues, we_s/addr_s/wd_s SHALL be driven from the granted master in the same cycle; otherwise we_s=0, addr_s=0, wd_s=0.
REQ-022 A read issued in cycle N SHALL produce rvalid_m[i]=1 and rd_m=rd_s in cycle N+1 only; a write produces no rvalid.
REQ-023 On issue with lock_m[i]=1 and burst_cnt+1 < MAX_BURST, the next state SHALL be LOCKED with owner i and burst_cnt incremented.
REQ-024 On issue with lock_m[i]=0, or burst_cnt+1 == MAX_BURST, the next state SHALL be IDLE, burst_cnt cleared, last set to i (forced release).
REQ-025 In LOCKED with req_m[owner]=0, the FSM SHALL return to IDLE and clear burst_cnt, keeping last = owner.
REQ-026 Back-to-back transactions SHALL be supported: a new issue is allowed in the cycle in which rvalid of the previous read is high.
REQ-027 rd_m SHALL hold its last value when rvalid_m is zero.

Reset
REQ-028 While reset is high: state=IDLE, last=1 (master 0 has priority first), burst_cnt=0, rvalid_m=0, rd_m=0; gnt_m follows REQ-019 combinationally but nothing issues until reset deasserts.
REQ-029 Reset asserted mid-transaction SHALL drop a pending rvalid immediately (asynchronous).

Configuration
REQ-030 With macro BUS_ARBITER_FIXED_PRIO_EN defined, IDLE arbitration SHALL always favour master 0 and last is ignored; without it, round-robin per REQ-019 applies.

Verification
REQ-031 Reset release, req_m=2'b11 reads to 0x1000/0x1004 -> gnt_m=01 first, then 10 next cycle; rvalid_m=01 then 10.
REQ-032 Master 0 writes 0xDEADBEEF to 0x1010, master 1 reads 0x1010 next cycle -> rd_m=0xDEADBEEF with rvalid_m=10.
REQ-033 Master 1 locked burst of 6 reads from 0x1100 while master 0 requests -> master 1 served 4 consecutive cycles, then master 0 granted, then master 1 resumes.
REQ-034 Master 0 drops req_m in LOCKED -> IDLE next cycle; master 1 granted same cycle it requests.
REQ-035 Reset asserted cycle after a read issues -> rvalid_m=00 immediately, state IDLE, master 0 wins first post-reset arbitration.
REQ-036 With BUS_ARBITER_FIXED_PRIO_EN, continuous req_m=11 unlocked for 8 cycles -> gnt_m=01 every cycle.

Source files
------------

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master to one-slave bus arbiter with optional bus locking. Master 0 is
// the core data port and master 1 is a secondary master. An owner may keep
// the bus for up to MAX_BURST consecutive locked transactions before it is
// forced to release it.
//
// A transaction issues in any cycle where req_m[i] and gnt_m[i] are both high.
// The slave side is a synchronous memory: read data arrives on rd_s one cycle
// after the address and is forwarded to both masters on rd_m, with rvalid_m
// marking the master that issued the read.
//
// Configuration macro:
//   BUS_ARBITER_FIXED_PRIO_EN - when defined, idle arbitration always favours
//                               master 0. When undefined (default), the two
//                               masters alternate on contention (round-robin).
//
// Parameters:
//   DATA_W    - data width
//   ADDR_W    - address width
//   MAX_BURST - max consecutive locked transactions per owner (1..15)
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   reset     in   asynchronous active-high reset
//   req_m     in   [1:0]        per-master transaction request
//   lock_m    in   [1:0]        per-master request to keep the bus
//   we_m      in   [1:0]        per-master write enable
//   addr_m    in   [2*ADDR_W]   packed addresses, master i at [i*ADDR_W +: ADDR_W]
//   wd_m      in   [2*DATA_W]   packed write data, same packing as addr_m
//   gnt_m     out  [1:0]        one-hot-or-zero grant (combinational)
//   rvalid_m  out  [1:0]        read data valid per master
//   rd_m      out  [DATA_W]     read data broadcast to both masters
//   we_s      out               slave write enable
//   addr_s    out  [ADDR_W]     slave address
//   wd_s      out  [DATA_W]     slave write data
//   rd_s      in   [DATA_W]     slave read data, one cycle after address
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_m,
  input  logic [1:0]            lock_m,
  input  logic [1:0]            we_m,
  input  logic [2*ADDR_W-1:0]   addr_m,
  input  logic [2*DATA_W-1:0]   wd_m,
  output logic [1:0]            gnt_m,
  output logic [1:0]            rvalid_m,
  output logic [DATA_W-1:0]     rd_m,
  output logic                  we_s,
  output logic [ADDR_W-1:0]     addr_s,
  output logic [DATA_W-1:0]     wd_s,
  input  logic [DATA_W-1:0]     rd_s
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [4:0] MAX_BURST_C = 5'(MAX_BURST);

  state_t              state_r;
  logic                owner_r;
  logic                last_r;
  logic [3:0]          burst_cnt_r;
  logic [1:0]          rvalid_r;
  logic [DATA_W-1:0]   rd_hold_r;

  logic [1:0]          gnt_s;
  logic                issue_s;
  logic                idx_s;
  logic [4:0]          burst_next_s;
  logic                keep_lock_s;

  // Grant selection: owner-only while locked, otherwise arbitrate requesters.
  always_comb begin
    gnt_s = 2'b00;
    if (state_r == ST_LOCKED) begin
      if (req_m[owner_r]) begin
        gnt_s = owner_r ? 2'b10 : 2'b01;
      end else begin
        gnt_s = 2'b00;
      end
    end else begin
      case (req_m)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
`ifdef BUS_ARBITER_FIXED_PRIO_EN
        2'b11:   gnt_s = 2'b01;
`else
        // On contention the master that was not served last wins.
        2'b11:   gnt_s = last_r ? 2'b01 : 2'b10;
`endif
        default: gnt_s = 2'b00;
      endcase
    end
  end

  assign gnt_m = gnt_s;

  // A transaction never issues while reset is held, even though the grant
  // itself keeps following the request lines.
  assign issue_s      = ~reset & (|(req_m & gnt_s));
  assign idx_s        = gnt_s[1];
  assign burst_next_s = {1'b0, burst_cnt_r} + 5'd1;
  assign keep_lock_s  = burst_next_s < MAX_BURST_C;

  // Slave-side request mux: driven from the granted master only while issuing.
  always_comb begin
    we_s   = 1'b0;
    addr_s = {ADDR_W{1'b0}};
    wd_s   = {DATA_W{1'b0}};
    if (issue_s) begin
      we_s   = we_m[idx_s];
      addr_s = idx_s ? addr_m[2*ADDR_W-1:ADDR_W] : addr_m[ADDR_W-1:0];
      wd_s   = idx_s ? wd_m[2*DATA_W-1:DATA_W]   : wd_m[DATA_W-1:0];
    end else begin
      we_s   = 1'b0;
      addr_s = {ADDR_W{1'b0}};
      wd_s   = {DATA_W{1'b0}};
    end
  end

  // Ownership FSM, burst counter, round-robin pointer and read-valid pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      owner_r     <= 1'b0;
      last_r      <= 1'b1;
      burst_cnt_r <= 4'd0;
      rvalid_r    <= 2'b00;
      rd_hold_r   <= {DATA_W{1'b0}};
    end else begin
      // Capture returned data so rd_m holds it once rvalid drops.
      if (|rvalid_r) begin
        rd_hold_r <= rd_s;
      end else begin
        rd_hold_r <= rd_hold_r;
      end

      if (issue_s) begin
        rvalid_r <= we_m[idx_s] ? 2'b00 : gnt_s;
        if (lock_m[idx_s] && keep_lock_s) begin
          state_r     <= ST_LOCKED;
          owner_r     <= idx_s;
          burst_cnt_r <= burst_next_s[3:0];
          last_r      <= last_r;
        end else begin
          // Voluntary release or burst limit reached.
          state_r     <= ST_IDLE;
          owner_r     <= owner_r;
          burst_cnt_r <= 4'd0;
          last_r      <= idx_s;
        end
      end else begin
        rvalid_r <= 2'b00;
        if (state_r == ST_LOCKED) begin
          // Locked but no issue means the owner dropped its request.
          state_r     <= ST_IDLE;
          owner_r     <= owner_r;
          burst_cnt_r <= 4'd0;
          last_r      <= owner_r;
        end else begin
          state_r     <= state_r;
          owner_r     <= owner_r;
          burst_cnt_r <= burst_cnt_r;
          last_r      <= last_r;
        end
      end
    end
  end

  assign rvalid_m = rvalid_r;
  // Read data is passed straight through in the valid cycle, held otherwise.
  assign rd_m     = (|rvalid_r) ? rd_s : rd_hold_r;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic         clk;
  logic         reset;
  logic [1:0]   req_m;
  logic [1:0]   lock_m;
  logic [1:0]   we_m;
  logic [63:0]  addr_m;
  logic [63:0]  wd_m;
  logic [1:0]   gnt_m;
  logic [1:0]   rvalid_m;
  logic [31:0]  rd_m;
  logic         we_s;
  logic [31:0]  addr_s;
  logic [31:0]  wd_s;
  logic [31:0]  rd_s;

  int n_cmp;
  int n_bad;

  logic [31:0] mem [0:255];

  bus_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_BURST(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_m    (req_m),
    .lock_m   (lock_m),
    .we_m     (we_m),
    .addr_m   (addr_m),
    .wd_m     (wd_m),
    .gnt_m    (gnt_m),
    .rvalid_m (rvalid_m),
    .rd_m     (rd_m),
    .we_s     (we_s),
    .addr_s   (addr_s),
    .wd_s     (wd_s),
    .rd_s     (rd_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous slave memory: word index addr[9:2], preset to A5A500xx.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      rd_s <= 32'h0;
    end else begin
      if (we_s) mem[addr_s[9:2]] <= wd_s;
      rd_s <= mem[addr_s[9:2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, drive new inputs 1 ns after the edge, settle 4 ns.
  task automatic cyc(input logic [1:0] rq, input logic [1:0] lk, input logic [1:0] wr,
                     input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0);
    @(posedge clk);
    #1;
    req_m  = rq;
    lock_m = lk;
    we_m   = wr;
    addr_m = {a1, a0};
    wd_m   = {32'h0, d0};
    #4;
  endtask

  initial begin
    logic [1:0] exp_g;
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b1;
    req_m  = 2'b00;
    lock_m = 2'b00;
    we_m   = 2'b00;
    addr_m = 64'h0;
    wd_m   = 64'h0;

    // Held in reset with both masters requesting: grant visible, nothing issues.
    cyc(2'b11, 2'b00, 2'b00, 32'h1000, 32'h1004, 32'h0);
    check("rst_gnt",    gnt_m,    2'b01);
    check("rst_rvalid", rvalid_m, 2'b00);
    check("rst_rd",     rd_m,     32'h0);
    check("rst_we",     we_s,     1'b0);
    check("rst_addr",   addr_s,   32'h0);

    // Release: master 0 wins first, then master 1.
    @(posedge clk);
    #1 reset = 1'b0;
    #4;
    check("a_gnt",    gnt_m,    2'b01);
    check("a_addr",   addr_s,   32'h1000);
    check("a_rvalid", rvalid_m, 2'b00);
    cyc(2'b11, 2'b00, 2'b00, 32'h1000, 32'h1004, 32'h0);
    check("b_gnt",    gnt_m,    2'b10);
    check("b_addr",   addr_s,   32'h1004);
    check("b_rvalid", rvalid_m, 2'b01);
    check("b_rd",     rd_m,     32'hA5A5_0000);

    // Master 0 writes, master 1 reads the same word back.
    cyc(2'b01, 2'b00, 2'b01, 32'h1010, 32'h1004, 32'hDEAD_BEEF);
    check("c_gnt",    gnt_m,    2'b01);
    check("c_we",     we_s,     1'b1);
    check("c_wd",     wd_s,     32'hDEAD_BEEF);
    check("c_addr",   addr_s,   32'h1010);
    check("c_rvalid", rvalid_m, 2'b10);
    check("c_rd",     rd_m,     32'hA5A5_0001);
    cyc(2'b10, 2'b00, 2'b00, 32'h0, 32'h1010, 32'h0);
    check("d_gnt",    gnt_m,    2'b10);
    check("d_rvalid", rvalid_m, 2'b00);
    check("d_rdhold", rd_m,     32'hA5A5_0001);
    check("d_we",     we_s,     1'b0);
    cyc(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
    check("e_gnt",    gnt_m,    2'b00);
    check("e_rvalid", rvalid_m, 2'b10);
    check("e_rd",     rd_m,     32'hDEAD_BEEF);
    check("e_addr",   addr_s,   32'h0);

    // Master 1 locked burst while master 0 competes: 4 beats, then master 0.
    cyc(2'b10, 2'b10, 2'b00, 32'h1200, 32'h1100, 32'h0);
    check("f_gnt",    gnt_m,    2'b10);
    check("f_addr",   addr_s,   32'h1100);
    cyc(2'b11, 2'b10, 2'b00, 32'h1200, 32'h1104, 32'h0);
    check("g_gnt",    gnt_m,    2'b10);
    check("g_rvalid", rvalid_m, 2'b10);
    check("g_rd",     rd_m,     32'hA5A5_0040);
    cyc(2'b11, 2'b10, 2'b00, 32'h1200, 32'h1108, 32'h0);
    check("h_gnt",    gnt_m,    2'b10);
    cyc(2'b11, 2'b10, 2'b00, 32'h1200, 32'h110C, 32'h0);
    check("i_gnt",    gnt_m,    2'b10);
    check("i_addr",   addr_s,   32'h110C);
    cyc(2'b11, 2'b10, 2'b00, 32'h1200, 32'h1110, 32'h0);
    check("j_gnt",    gnt_m,    2'b01);
    check("j_addr",   addr_s,   32'h1200);
    check("j_rvalid", rvalid_m, 2'b10);
    check("j_rd",     rd_m,     32'hA5A5_0043);
    cyc(2'b11, 2'b10, 2'b00, 32'h1200, 32'h1110, 32'h0);
    check("k_gnt",    gnt_m,    2'b10);
    check("k_addr",   addr_s,   32'h1110);
    check("k_rvalid", rvalid_m, 2'b01);
    check("k_rd",     rd_m,     32'hA5A5_0080);
    cyc(2'b11, 2'b00, 2'b00, 32'h1200, 32'h1114, 32'h0);
    check("l_gnt",    gnt_m,    2'b10);
    check("l_addr",   addr_s,   32'h1114);

    // Master 0 locks then drops its request: no grant, then IDLE grants master 1.
    cyc(2'b01, 2'b01, 2'b00, 32'h1020, 32'h0, 32'h0);
    check("m_gnt",    gnt_m,    2'b01);
    cyc(2'b10, 2'b00, 2'b00, 32'h0, 32'h1030, 32'h0);
    check("n_gnt",    gnt_m,    2'b00);
    check("n_rvalid", rvalid_m, 2'b01);
    check("n_we",     we_s,     1'b0);
    cyc(2'b10, 2'b00, 2'b00, 32'h0, 32'h1030, 32'h0);
    check("o_gnt",    gnt_m,    2'b10);
    check("o_addr",   addr_s,   32'h1030);

    // Master 0 reads, then reset lands while its rvalid is pending.
    cyc(2'b01, 2'b00, 2'b00, 32'h1040, 32'h0, 32'h0);
    check("p_gnt",    gnt_m,    2'b01);
    check("p_rvalid", rvalid_m, 2'b10);
    cyc(2'b00, 2'b00, 2'b00, 32'h1040, 32'h1044, 32'h0);
    check("q_rvalid", rvalid_m, 2'b01);
    #1 reset = 1'b1;
    #1;
    check("q_rst_rvalid", rvalid_m, 2'b00);
    check("q_rst_rd",     rd_m,     32'h0);
    req_m = 2'b11;
    #1;
    check("q_rst_gnt", gnt_m, 2'b01);
    check("q_rst_we",  we_s,  1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    #4;
    check("r_gnt",    gnt_m,    2'b01);
    check("r_addr",   addr_s,   32'h1040);
    check("r_rvalid", rvalid_m, 2'b00);

    // Continuous unlocked contention: alternation, or always master 0 if fixed.
    for (int i = 1; i < 8; i++) begin
      cyc(2'b11, 2'b00, 2'b00, 32'h1040, 32'h1044, 32'h0);
`ifdef BUS_ARBITER_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`endif
      check("rr_gnt", gnt_m, exp_g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
